// File: rtl/dram_test_pkg.sv
// Shared types for the xc7 LUTRAM hardware tests.
// Depth/address constants plus address and occupancy types.
package dram_test_pkg;
  localparam int DRAM32_DEPTH = 32;
  localparam int DRAM32_AW = 5;

  typedef logic [DRAM32_AW-1:0] dram_addr_t;
  typedef logic [DRAM32_AW:0]   dram_level_t;
endpackage

// File: rtl/dram32_bank.sv
// WIDTH-bit wide, 32-deep bank of RAM32X1D cells.
// Ports: clk/we/wr_addr/wr_data write side, rd_addr -> rd_data async read.

// Behavioural stand-in for the RAM32X1D dual-port LUTRAM cell.
module RAM32X1D #(
  parameter logic [31:0] INIT = 32'h0
) (
  input  logic WCLK,
  input  logic WE,
  input  logic D,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic DPRA0,
  input  logic DPRA1,
  input  logic DPRA2,
  input  logic DPRA3,
  input  logic DPRA4,
  output logic SPO,
  output logic DPO
);
  logic [31:0] mem = INIT;

  always_ff @(posedge WCLK)
    if (WE) mem[{A4, A3, A2, A1, A0}] <= D;

  assign SPO = mem[{A4, A3, A2, A1, A0}];
  assign DPO = mem[{DPRA4, DPRA3, DPRA2, DPRA1, DPRA0}];
endmodule

module dram32_bank
  import dram_test_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] INIT  = 32'h0
) (
  input  logic             clk,
  input  logic             we,
  input  dram_addr_t       wr_addr,
  input  dram_addr_t       rd_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    RAM32X1D #(.INIT(INIT)) u_ram (
      .WCLK  (clk),
      .WE    (we),
      .D     (wr_data[i]),
      .A0    (wr_addr[0]),
      .A1    (wr_addr[1]),
      .A2    (wr_addr[2]),
      .A3    (wr_addr[3]),
      .A4    (wr_addr[4]),
      .DPRA0 (rd_addr[0]),
      .DPRA1 (rd_addr[1]),
      .DPRA2 (rd_addr[2]),
      .DPRA3 (rd_addr[3]),
      .DPRA4 (rd_addr[4]),
      .SPO   (),
      .DPO   (rd_data[i])
    );
  end
endmodule

// File: rtl/dram_fifo_ctrl.sv
// 32-deep FIFO controller over a RAM32X1D bank.
// Ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/
// out_data, level, almost_full, overflow, underflow (sticky).
module dram_fifo_ctrl
  import dram_test_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          AFULL_LEVEL = 28,
  parameter logic [31:0] INIT        = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [5:0]       level,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);
  localparam dram_level_t FULL_LVL = dram_level_t'(DRAM32_DEPTH);
  localparam dram_level_t AF_LVL   = dram_level_t'(AFULL_LEVEL);

  dram_addr_t  wr_ptr;
  dram_addr_t  rd_ptr;
  dram_level_t level_q;
  dram_level_t level_next;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        we;

  assign full      = level_q == FULL_LVL;
  assign empty     = level_q == '0;
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  // rst gates WE so an async reset stops writes without waiting for an edge.
  assign we        = push & ~rst;
  assign level     = level_q;

  always_comb begin
    level_next = level_q;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level_q + 1'b1;
    else if (pop && !push)
      level_next = level_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      level_q     <= level_next;
      almost_full <= level_next >= AF_LVL;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (in_valid && full)   overflow  <= 1'b1;
        if (out_ready && empty) underflow <= 1'b1;
      end
    end
  end

  dram32_bank #(
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) u_bank (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .rd_addr (rd_ptr),
    .wr_data (in_data),
    .rd_data (out_data)
  );
endmodule
